// File: rtl/cond_flag_unit.sv
// Architectural NZCV flag register plus ARM condition-code evaluation.
// Gates the decoder's PC, register and memory write requests by the condition result.
module cond_flag_unit #(
  parameter int NUM_FLAGS = 4
) (
  input  logic                 CLK,
  input  logic                 RESETn,
  input  logic [3:0]           Cond,
  input  logic [NUM_FLAGS-1:0] ALUFlags,
  input  logic [1:0]           FlagW,
  input  logic                 PCS,
  input  logic                 RegW,
  input  logic                 MemW,
  input  logic                 NoWrite,
  input  logic                 Stall,
  output logic                 PCSrc,
  output logic                 RegWrite,
  output logic                 MemWrite,
  output logic                 CondEx,
  output logic [NUM_FLAGS-1:0] Flags,
  output logic                 CarryIn
);

  logic [NUM_FLAGS-1:0] flags_q;
  logic                 n_f, z_f, c_f, v_f;
  logic                 go;

  assign n_f = flags_q[3];
  assign z_f = flags_q[2];
  assign c_f = flags_q[1];
  assign v_f = flags_q[0];

  // Conditions look only at the stored flags, never at this cycle's ALU output.
  always_comb begin
    CondEx = 1'b0;
    case (Cond)
      4'b0000: CondEx = z_f;
      4'b0001: CondEx = ~z_f;
      4'b0010: CondEx = c_f;
      4'b0011: CondEx = ~c_f;
      4'b0100: CondEx = n_f;
      4'b0101: CondEx = ~n_f;
      4'b0110: CondEx = v_f;
      4'b0111: CondEx = ~v_f;
      4'b1000: CondEx = c_f & ~z_f;
      4'b1001: CondEx = ~c_f | z_f;
      4'b1010: CondEx = (n_f == v_f);
      4'b1011: CondEx = (n_f != v_f);
      4'b1100: CondEx = ~z_f & (n_f == v_f);
      4'b1101: CondEx = z_f | (n_f != v_f);
      default: CondEx = 1'b1;
    endcase
  end

  // Reset also forces the gated requests low so nothing commits during reset.
  assign go       = CondEx & ~Stall & RESETn;
  assign PCSrc    = PCS & go;
  assign RegWrite = RegW & go & ~NoWrite;
  assign MemWrite = MemW & go;

  // NZ and CV halves are written independently.
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      flags_q <= '0;
    end else begin
      if (go & FlagW[1]) flags_q[3:2] <= ALUFlags[3:2];
      if (go & FlagW[0]) flags_q[1:0] <= ALUFlags[1:0];
    end
  end

  assign Flags   = flags_q;
  assign CarryIn = flags_q[1];

endmodule
